// File: rtl/height_differentiator.sv
// Finite-difference velocity from a stream of unsigned height samples, with saturation and a sticky overflow flag.
// Define ACCEL_OUT_EN to add the second-difference outputs accel_out / accel_valid.
module height_differentiator #(
    parameter int N        = 64,
    parameter int DT_SHIFT = 0
) (
    input  logic                CLK,
    input  logic                RESETB,
    input  logic                start_differentiation,
    input  logic                sample_valid,
    input  logic [N-1:0]        height_in,
    output logic signed [N-1:0] velocity_out,
    output logic                velocity_valid,
    output logic                overflow,
    output logic [31:0]         sample_count
`ifdef ACCEL_OUT_EN
    ,
    output logic signed [N-1:0] accel_out,
    output logic                accel_valid
`endif
);

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t              state_q;
    logic [N-1:0]        h_prev_q;
    logic signed [N-1:0] vel_q;
    logic                vld_q;
    logic                ovf_q;
    logic [31:0]         cnt_q;

    // Clamp an (N+1)-bit signed value into the N-bit signed range.
    function automatic logic signed [N-1:0] sat_n(input logic signed [N:0] x);
        logic signed [N-1:0] r;
        if (x[N] != x[N-1]) begin
            r = x[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end else begin
            r = x[N-1:0];
        end
        return r;
    endfunction

    function automatic logic sat_ovf(input logic signed [N:0] x);
        return x[N] ^ x[N-1];
    endfunction

    logic signed [N:0]   diff_d;
    logic signed [N:0]   shr_d;
    logic signed [N-1:0] vel_d;
    logic                vel_ovf_d;

    assign diff_d    = $signed({1'b0, height_in}) - $signed({1'b0, h_prev_q});
    assign shr_d     = diff_d >>> DT_SHIFT;
    assign vel_d     = sat_n(shr_d);
    assign vel_ovf_d = sat_ovf(shr_d);

`ifdef ACCEL_OUT_EN
    logic signed [N-1:0] acc_q;
    logic                acc_vld_q;
    logic                have_vel_q;
    logic signed [N:0]   acc_diff_d;
    logic                acc_ovf_d;

    // vel_q still holds the previous result when the new one is being formed.
    assign acc_diff_d = $signed({vel_d[N-1], vel_d}) - $signed({vel_q[N-1], vel_q});
    assign acc_ovf_d  = have_vel_q & sat_ovf(acc_diff_d);
    assign accel_out   = acc_q;
    assign accel_valid = acc_vld_q;
`endif

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            state_q  <= IDLE;
            h_prev_q <= '0;
            vel_q    <= '0;
            vld_q    <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
`ifdef ACCEL_OUT_EN
            acc_q      <= '0;
            acc_vld_q  <= 1'b0;
            have_vel_q <= 1'b0;
`endif
        end else begin
            vld_q <= 1'b0;
`ifdef ACCEL_OUT_EN
            acc_vld_q <= 1'b0;
`endif
            if (!start_differentiation) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q  <= PRIME;
                        ovf_q    <= 1'b0;
                        cnt_q    <= '0;
                        h_prev_q <= '0;
`ifdef ACCEL_OUT_EN
                        have_vel_q <= 1'b0;
`endif
                    end
                    PRIME: begin
                        if (sample_valid) begin
                            h_prev_q <= height_in;
                            state_q  <= RUN;
                        end
                    end
                    RUN: begin
                        if (sample_valid) begin
                            h_prev_q <= height_in;
                            vel_q    <= vel_d;
                            vld_q    <= 1'b1;
                            if (cnt_q != 32'hFFFF_FFFF) begin
                                cnt_q <= cnt_q + 32'd1;
                            end
`ifdef ACCEL_OUT_EN
                            ovf_q      <= ovf_q | vel_ovf_d | acc_ovf_d;
                            have_vel_q <= 1'b1;
                            if (have_vel_q) begin
                                acc_q     <= sat_n(acc_diff_d);
                                acc_vld_q <= 1'b1;
                            end
`else
                            ovf_q <= ovf_q | vel_ovf_d;
`endif
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign velocity_out   = vel_q;
    assign velocity_valid = vld_q;
    assign overflow       = ovf_q;
    assign sample_count   = cnt_q;

endmodule

// File: tb/tb_height_differentiator.sv
// Bench for height_differentiator: directed scenarios plus a randomized stream against an arithmetic model.
// Instance A: N=64, DT_SHIFT=0. Instance B: N=8, DT_SHIFT=2.
module tb_height_differentiator;

    logic CLK = 1'b0;
    logic RESETB = 1'b0;
    always #5 CLK = ~CLK;

    logic               sA = 1'b0, svA = 1'b0;
    logic [63:0]        hA = '0;
    logic signed [63:0] velA;
    logic               vvA, ovA;
    logic [31:0]        cntA;

    logic               sB = 1'b0, svB = 1'b0;
    logic [7:0]         hB = '0;
    logic signed [7:0]  velB;
    logic               vvB, ovB;
    logic [31:0]        cntB;

`ifdef ACCEL_OUT_EN
    logic signed [63:0] accA;
    logic               avA;
    logic signed [7:0]  accB;
    logic               avB;
`endif

    int total = 0;
    int bad   = 0;

    height_differentiator #(.N(64), .DT_SHIFT(0)) dutA (
        .CLK(CLK), .RESETB(RESETB), .start_differentiation(sA), .sample_valid(svA),
        .height_in(hA), .velocity_out(velA), .velocity_valid(vvA), .overflow(ovA),
        .sample_count(cntA)
`ifdef ACCEL_OUT_EN
        , .accel_out(accA), .accel_valid(avA)
`endif
    );

    height_differentiator #(.N(8), .DT_SHIFT(2)) dutB (
        .CLK(CLK), .RESETB(RESETB), .start_differentiation(sB), .sample_valid(svB),
        .height_in(hB), .velocity_out(velB), .velocity_valid(vvB), .overflow(ovB),
        .sample_count(cntB)
`ifdef ACCEL_OUT_EN
        , .accel_out(accB), .accel_valid(avB)
`endif
    );

    // Reference velocity: exact difference, floor-divide by 2^sh, clamp to n-bit signed range.
    function automatic logic signed [127:0] mdl_vel(input logic [127:0] h, input logic [127:0] p,
                                                    input int sh, input int n, output bit ov);
        logic signed [127:0] d, mx, mn;
        d  = $signed(h) - $signed(p);
        d  = d >>> sh;
        mx = (128'sd1 <<< (n - 1)) - 128'sd1;
        mn = -(128'sd1 <<< (n - 1));
        ov = 1'b0;
        if (d > mx) begin d = mx; ov = 1'b1; end
        else if (d < mn) begin d = mn; ov = 1'b1; end
        return d;
    endfunction

    task automatic pulse_a(input logic [63:0] h);
        @(negedge CLK); svA = 1'b1; hA = h;
        @(negedge CLK); svA = 1'b0;
    endtask

    task automatic pulse_b(input logic [7:0] h);
        @(negedge CLK); svB = 1'b1; hB = h;
        @(negedge CLK); svB = 1'b0;
    endtask

    task automatic restart_a;
        @(negedge CLK); sA = 1'b0;
        @(negedge CLK); sA = 1'b1;
    endtask

    task automatic restart_b;
        @(negedge CLK); sB = 1'b0;
        @(negedge CLK); sB = 1'b1;
    endtask

    task automatic test_reset;
        RESETB = 1'b0;
        sA = 1'b1; svA = 1'b1; hA = 64'd77;
        repeat (3) @(negedge CLK);
        total++; if (velA !== 64'd0) begin bad++; $display("FAIL reset_vel got=%h want=0", velA); end
        total++; if (vvA !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", vvA); end
        total++; if (ovA !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", ovA); end
        total++; if (cntA !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", cntA); end
        svA = 1'b0; sA = 1'b0;
        RESETB = 1'b1;
    endtask

    task automatic test_basic;
        restart_a;
        pulse_a(64'd100);
        total++; if (vvA !== 1'b0) begin bad++; $display("FAIL prime_novalid got=%b want=0", vvA); end
        pulse_a(64'd150);
        total++; if (vvA !== 1'b1 || velA !== 64'sd50) begin bad++; $display("FAIL vel50 got=%0d/%b want=50/1", velA, vvA); end
`ifdef ACCEL_OUT_EN
        total++; if (avA !== 1'b0) begin bad++; $display("FAIL accel_first got=%b want=0", avA); end
`endif
        pulse_a(64'd210);
        total++; if (vvA !== 1'b1 || velA !== 64'sd60) begin bad++; $display("FAIL vel60 got=%0d/%b want=60/1", velA, vvA); end
        total++; if (cntA !== 32'd2) begin bad++; $display("FAIL cnt2 got=%0d want=2", cntA); end
`ifdef ACCEL_OUT_EN
        total++; if (avA !== 1'b1 || accA !== 64'sd10) begin bad++; $display("FAIL accel10 got=%0d/%b want=10/1", accA, avA); end
`endif
        @(negedge CLK);
        total++; if (vvA !== 1'b0 || velA !== 64'sd60) begin bad++; $display("FAIL hold got=%0d/%b want=60/0", velA, vvA); end
        pulse_a(64'd200);
        total++; if (velA !== 64'hFFFF_FFFF_FFFF_FFF6 || ovA !== 1'b0) begin bad++; $display("FAIL neg10 got=%h/%b want=fffffffffffffff6/0", velA, ovA); end
    endtask

    task automatic test_overflow;
        restart_a;
        pulse_a(64'd0);
        pulse_a(64'h8000_0000_0000_0000);
        total++; if (velA !== 64'h7FFF_FFFF_FFFF_FFFF || ovA !== 1'b1) begin bad++; $display("FAIL sat_pos got=%h/%b want=7fffffffffffffff/1", velA, ovA); end
        pulse_a(64'h8000_0000_0000_0000);
        total++; if (velA !== 64'd0 || ovA !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%h/%b want=0/1", velA, ovA); end
    endtask

    task automatic test_start_drop;
        @(negedge CLK); sA = 1'b0; svA = 1'b1; hA = 64'd12345;
        @(negedge CLK); svA = 1'b0; sA = 1'b1;
        total++; if (vvA !== 1'b0) begin bad++; $display("FAIL drop_ignored got=%b want=0", vvA); end
        pulse_a(64'd5);
        pulse_a(64'd7);
        total++; if (vvA !== 1'b1 || velA !== 64'sd2) begin bad++; $display("FAIL restart_vel got=%0d/%b want=2/1", velA, vvA); end
        total++; if (ovA !== 1'b0 || cntA !== 32'd1) begin bad++; $display("FAIL restart_clr got=%b/%0d want=0/1", ovA, cntA); end
    endtask

    task automatic test_reset_mid_run;
        restart_a;
        pulse_a(64'd100);
        pulse_a(64'd150);
        @(negedge CLK); RESETB = 1'b0;
        #1;
        total++; if (velA !== 64'd0 || cntA !== 32'd0) begin bad++; $display("FAIL async_rst got=%0d/%0d want=0/0", velA, cntA); end
        @(negedge CLK); RESETB = 1'b1;
        pulse_a(64'd400);
        total++; if (vvA !== 1'b0) begin bad++; $display("FAIL rst_prime got=%b want=0", vvA); end
        pulse_a(64'd410);
        total++; if (vvA !== 1'b1 || velA !== 64'sd10 || cntA !== 32'd1) begin bad++; $display("FAIL rst_vel got=%0d/%b/%0d want=10/1/1", velA, vvA, cntA); end
    endtask

    task automatic test_dt_shift;
        restart_b;
        pulse_b(8'd0);
        pulse_b(8'd100);
        total++; if (vvB !== 1'b1 || velB !== 8'sd25) begin bad++; $display("FAIL shift25 got=%0d/%b want=25/1", velB, vvB); end
        pulse_b(8'd99);
        total++; if (velB !== 8'hFF || ovB !== 1'b0) begin bad++; $display("FAIL floor_m1 got=%h/%b want=ff/0", velB, ovB); end
        pulse_b(8'd0);
        total++; if (velB !== -8'sd25) begin bad++; $display("FAIL floor_m25 got=%0d want=-25", velB); end
    endtask

    task automatic test_random_stream;
        bit                  primed = 1'b0, have_mvel = 1'b0, exp_vld = 1'b0, movf = 1'b0, ov;
        logic [63:0]         mprev = '0, h;
        logic signed [127:0] v;
        logic [63:0]         mvel = '0;
        int unsigned         mcnt = 0;
        bit                  sv;
        restart_a;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (i > 0) begin
                total++; if (vvA !== exp_vld) begin bad++; $display("FAIL rnd_valid i=%0d got=%b want=%b", i, vvA, exp_vld); end
                if (have_mvel) begin
                    total++; if (velA !== mvel) begin bad++; $display("FAIL rnd_vel i=%0d got=%h want=%h", i, velA, mvel); end
                end
                total++; if (cntA !== mcnt || ovA !== movf) begin bad++; $display("FAIL rnd_cnt_ovf i=%0d got=%0d/%b want=%0d/%b", i, cntA, ovA, mcnt, movf); end
            end
            sv = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 0) h = {$urandom, $urandom};
            else h = mprev + 64'($urandom_range(0, 400)) - 64'd200;
            svA = sv; hA = h;
            exp_vld = 1'b0;
            if (sv) begin
                if (!primed) begin
                    primed = 1'b1;
                end else begin
                    v = mdl_vel({64'd0, h}, {64'd0, mprev}, 0, 64, ov);
                    mvel = v[63:0];
                    have_mvel = 1'b1;
                    exp_vld = 1'b1;
                    mcnt++;
                    movf = movf | ov;
                end
                mprev = h;
            end
        end
        @(negedge CLK); svA = 1'b0;
        total++; if (vvA !== exp_vld || cntA !== mcnt) begin bad++; $display("FAIL rnd_last got=%b/%0d want=%b/%0d", vvA, cntA, exp_vld, mcnt); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_overflow;
        test_start_drop;
        test_reset_mid_run;
        test_dt_shift;
        test_random_stream;
        repeat (2) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
